// File: rtl/rst_seq_pkg.sv
// Shared types and helpers for the reset/clock bring-up sequencer.
// No logic of its own; pure elaboration-time definitions.
// No flow control.
package rst_seq_pkg;

    // Sequencer states in bring-up order; FAIL is terminal until sw_req/reset.
    typedef enum logic [2:0] {
        ST_HOLD,
        ST_DCM,
        ST_LOCK,
        ST_REL,
        ST_DONE,
        ST_FAIL
    } state_t;

    // Bits needed to hold values 0..value-1, never less than 1 so that
    // degenerate parameters still give a legal vector width.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((longint'(1) << i) < longint'(value)) begin
                r = i + 1;
            end
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/rst_seq_sync.sv
// Two-flop synchroniser for a single asynchronous level.
// Latency: 2 clock cycles from input change to o_q.
// No flow control; resets to 0 so a lock is never assumed during reset.
module rst_seq_sync (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    // First stage may go metastable; second stage gives a clean level.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/rst_seq.sv
// Reset/clock bring-up sequencer: GTS hold, DCM reset + lock wait with retry, ordered domain release.
// Latency: outputs are registered; lock changes act 2 cycles late through the synchroniser.
// No flow control; sw_req is a single-cycle pulse honoured in every state except HOLD.
module rst_seq
    import rst_seq_pkg::*;
#(
    parameter int N_DOM        = 4,
    parameter int CNT_W        = 16,
    parameter int GTS_CYC      = 20,
    parameter int DCM_PULSE    = 10,
    parameter int LOCK_STABLE  = 4,
    parameter int LOCK_TIMEOUT = 1000,
    parameter int MAX_RETRY    = 3,
    parameter int REL_GAP      = 10
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            dcm_locked,
    input  logic                            sw_req,
    output logic                            gts,
    output logic                            dcm_rst,
    output logic [N_DOM-1:0]                dom_rst,
    output logic                            seq_done,
    output logic                            seq_fail,
    output logic [clog2(MAX_RETRY+1)-1:0]   retry_cnt
);

    localparam int     RW          = clog2(MAX_RETRY + 1);
    localparam int     SW          = clog2(LOCK_STABLE + 1);
    localparam longint L_CNT_MAX   = (longint'(1) << CNT_W) - 1;

    // Every timed phase must be reachable by the shared counter.
    if (longint'(GTS_CYC) > L_CNT_MAX || longint'(DCM_PULSE) > L_CNT_MAX ||
        longint'(LOCK_TIMEOUT) > L_CNT_MAX || longint'(REL_GAP) > L_CNT_MAX ||
        longint'(LOCK_STABLE) > L_CNT_MAX || GTS_CYC < 1 || DCM_PULSE < 1 ||
        LOCK_TIMEOUT < 1 || REL_GAP < 1 || LOCK_STABLE < 1) begin : g_bad_timing
        $error("rst_seq: timing parameter does not fit the CNT_W counter");
    end
    if (N_DOM < 1 || N_DOM > 16) begin : g_bad_ndom
        $error("rst_seq: N_DOM must be 1..16");
    end

    localparam logic [CNT_W-1:0] L_GTS_END   = CNT_W'(GTS_CYC - 1);
    localparam logic [CNT_W-1:0] L_DCM_END   = CNT_W'(DCM_PULSE - 1);
    localparam logic [CNT_W-1:0] L_TMO_END   = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] L_GAP_END   = CNT_W'(REL_GAP - 1);
    localparam logic [SW-1:0]    L_STAB_END  = SW'(LOCK_STABLE - 1);
    localparam logic [RW-1:0]    L_RETRY_MAX = RW'(MAX_RETRY);
    localparam logic [N_DOM-1:0] L_ALL_RST   = {N_DOM{1'b1}};

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [SW-1:0]    r_stab;
    logic             r_gts;
    logic             r_dcm_rst;
    logic [N_DOM-1:0] r_dom_rst;
    logic             r_seq_done;
    logic             r_seq_fail;
    logic [RW-1:0]    r_retry;

    state_t           w_state_nxt;
    logic             w_cnt_clr;
    logic [SW-1:0]    w_stab_nxt;
    logic             w_gts_nxt;
    logic             w_dcm_nxt;
    logic [N_DOM-1:0] w_dom_nxt;
    logic             w_done_nxt;
    logic             w_fail_nxt;
    logic [RW-1:0]    w_retry_nxt;
    logic             w_lk;

    rst_seq_sync u_lock_sync (
        .i_clk (clk),
        .i_rst (reset),
        .i_d   (dcm_locked),
        .o_q   (w_lk)
    );

    // Next state and next registered outputs. Domain release is a left
    // shift of the reset vector, so bits can only fall in index order and
    // every reassertion loads all ones at once.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_clr   = 1'b0;
        w_stab_nxt  = '0;
        w_gts_nxt   = r_gts;
        w_dcm_nxt   = r_dcm_rst;
        w_dom_nxt   = r_dom_rst;
        w_done_nxt  = r_seq_done;
        w_fail_nxt  = r_seq_fail;
        w_retry_nxt = r_retry;

        case (r_state)
            ST_HOLD: begin
                if (r_cnt == L_GTS_END) begin
                    w_state_nxt = ST_DCM;
                    w_gts_nxt   = 1'b0;
                    w_dcm_nxt   = 1'b1;
                end
            end
            ST_DCM: begin
                if (r_cnt == L_DCM_END) begin
                    w_state_nxt = ST_LOCK;
                    w_dcm_nxt   = 1'b0;
                end
            end
            ST_LOCK: begin
                if (w_lk) begin
                    w_stab_nxt = r_stab + SW'(1);
                end
                // Success is tested first so it wins over a coincident timeout.
                if (w_lk && r_stab == L_STAB_END) begin
                    w_state_nxt = ST_REL;
                    w_retry_nxt = '0;
                    w_dom_nxt   = r_dom_rst << 1;
                end else if (r_cnt == L_TMO_END) begin
                    if (r_retry < L_RETRY_MAX) begin
                        w_retry_nxt = r_retry + RW'(1);
                        w_state_nxt = ST_DCM;
                        w_dcm_nxt   = 1'b1;
                    end else begin
                        w_state_nxt = ST_FAIL;
                        w_fail_nxt  = 1'b1;
                    end
                end
            end
            ST_REL: begin
                if (!w_lk) begin
                    w_dom_nxt   = L_ALL_RST;
                    w_state_nxt = ST_DCM;
                    w_dcm_nxt   = 1'b1;
                end else if (r_dom_rst == '0) begin
                    w_state_nxt = ST_DONE;
                    w_done_nxt  = 1'b1;
                end else if (r_cnt == L_GAP_END) begin
                    w_dom_nxt = r_dom_rst << 1;
                    w_cnt_clr = 1'b1;
                end
            end
            ST_DONE: begin
                if (!w_lk) begin
                    w_done_nxt  = 1'b0;
                    w_dom_nxt   = L_ALL_RST;
                    w_state_nxt = ST_DCM;
                    w_dcm_nxt   = 1'b1;
                end
            end
            ST_FAIL: begin
                w_dom_nxt = L_ALL_RST;
                w_dcm_nxt = 1'b0;
            end
            default: begin
                w_state_nxt = ST_HOLD;
            end
        endcase

        // Software re-sequence outranks lock loss and timeout.
        if (sw_req && r_state != ST_HOLD) begin
            w_state_nxt = ST_DCM;
            w_cnt_clr   = 1'b1;
            w_gts_nxt   = 1'b0;
            w_dcm_nxt   = 1'b1;
            w_dom_nxt   = L_ALL_RST;
            w_done_nxt  = 1'b0;
            w_fail_nxt  = 1'b0;
            w_retry_nxt = '0;
        end

        if (w_state_nxt != ST_LOCK || r_state != ST_LOCK) begin
            w_stab_nxt = '0;
        end
    end

    // State, counters and output registers; async reset gives the safe state at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_HOLD;
            r_cnt      <= '0;
            r_stab     <= '0;
            r_gts      <= 1'b1;
            r_dcm_rst  <= 1'b0;
            r_dom_rst  <= L_ALL_RST;
            r_seq_done <= 1'b0;
            r_seq_fail <= 1'b0;
            r_retry    <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_stab     <= w_stab_nxt;
            r_gts      <= w_gts_nxt;
            r_dcm_rst  <= w_dcm_nxt;
            r_dom_rst  <= w_dom_nxt;
            r_seq_done <= w_done_nxt;
            r_seq_fail <= w_fail_nxt;
            r_retry    <= w_retry_nxt;
            if (w_state_nxt != r_state || w_cnt_clr) begin
                r_cnt <= '0;
            end else if (r_cnt != '1) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign gts       = r_gts;
    assign dcm_rst   = r_dcm_rst;
    assign dom_rst   = r_dom_rst;
    assign seq_done  = r_seq_done;
    assign seq_fail  = r_seq_fail;
    assign retry_cnt = r_retry;

endmodule
